// File: rtl/spi_slave_if.sv
// SPI slave bus: serial pins plus the parallel RAM-side handshake.
// SPI_SLAVE_CMD_CHK_EN adds the cmd_err strobe.
interface spi_slave_if #(
  parameter int unsigned DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
`ifdef SPI_SLAVE_CMD_CHK_EN
  logic              cmd_err;
`endif

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
`ifdef SPI_SLAVE_CMD_CHK_EN
    , output cmd_err
`endif
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
`ifdef SPI_SLAVE_CMD_CHK_EN
    , input cmd_err
`endif
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave front end for the single-port RAM: 10-bit MOSI frames in, 8-bit MISO read bursts out.
// Optional command check and cmd_err output enabled by SPI_SLAVE_CMD_CHK_EN.
module spi_slave #(
  parameter int unsigned DATA_W = 8
) (
  input logic       clk,
  input logic       rst_n,
  spi_slave_if.slave bus
);
  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned SHIFT_W = FRAME_W - 1;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TXC_W   = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  // Sub-phase inside the three frame states
  typedef enum logic [1:0] {PH_RX, PH_WAIT, PH_BURST, PH_HOLD} phase_t;

  state_t             state_q, state_d;
  phase_t             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               miso_q, miso_d;
  logic               rd_addr_flag_q, rd_addr_flag_d;
`ifdef SPI_SLAVE_CMD_CHK_EN
  logic               cmd_err_q, cmd_err_d;
`endif

  logic [FRAME_W-1:0] frame_c;
  logic               frame_ok_c;

  // Complete frame as it would stand after the current MOSI bit is taken
  assign frame_c = {shift_q, bus.MOSI};

`ifdef SPI_SLAVE_CMD_CHK_EN
  always_comb begin
    frame_ok_c = 1'b1;
    case (state_q)
      READ_ADD:  frame_ok_c = ~frame_c[FRAME_W-2];
      READ_DATA: frame_ok_c = frame_c[FRAME_W-2];
      WRITE:     frame_ok_c = ~frame_c[FRAME_W-1];
      default:   frame_ok_c = 1'b1;
    endcase
  end
`else
  assign frame_ok_c = 1'b1;
`endif

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    cnt_d          = cnt_q;
    tx_cnt_d       = tx_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = miso_q;
    rd_addr_flag_d = rd_addr_flag_q;
`ifdef SPI_SLAVE_CMD_CHK_EN
    cmd_err_d      = 1'b0;
`endif
    if (bus.SS_n) begin
      // Deselect aborts whatever is in flight; the read-address flag survives
      state_d  = IDLE;
      phase_d  = PH_RX;
      cnt_d    = '0;
      tx_cnt_d = '0;
      shift_d  = '0;
      miso_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = CHK_CMD;
        CHK_CMD: begin
          shift_d = SHIFT_W'(bus.MOSI);
          cnt_d   = CNT_W'(FRAME_W - 2);
          phase_d = PH_RX;
          if (!bus.MOSI)          state_d = WRITE;
          else if (rd_addr_flag_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          case (phase_q)
            PH_RX: begin
              shift_d = frame_c[SHIFT_W-1:0];
              if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
              end else begin
                phase_d = PH_HOLD;
                if (frame_ok_c) begin
                  rx_data_d  = frame_c;
                  rx_valid_d = 1'b1;
                  if (state_q == READ_ADD) rd_addr_flag_d = 1'b1;
                  if (state_q == READ_DATA) begin
                    rd_addr_flag_d = 1'b0;
                    phase_d        = PH_WAIT;
                  end
                end
`ifdef SPI_SLAVE_CMD_CHK_EN
                else begin
                  cmd_err_d = 1'b1;
                end
`endif
              end
            end
            PH_WAIT: begin
              if (bus.tx_valid) begin
                shift_d  = SHIFT_W'(bus.tx_data);
                miso_d   = bus.tx_data[DATA_W-1];
                tx_cnt_d = TXC_W'(DATA_W - 1);
                phase_d  = PH_BURST;
              end
            end
            PH_BURST: begin
              if (tx_cnt_q != '0) begin
                miso_d   = shift_q[DATA_W-2];
                shift_d  = shift_q << 1;
                tx_cnt_d = tx_cnt_q - TXC_W'(1);
              end else begin
                miso_d  = 1'b0;
                phase_d = PH_HOLD;
              end
            end
            default: phase_d = phase_q;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      phase_q        <= PH_RX;
      cnt_q          <= '0;
      tx_cnt_q       <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_flag_q <= 1'b0;
`ifdef SPI_SLAVE_CMD_CHK_EN
      cmd_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      tx_cnt_q       <= tx_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
      rd_addr_flag_q <= rd_addr_flag_d;
`ifdef SPI_SLAVE_CMD_CHK_EN
      cmd_err_q      <= cmd_err_d;
`endif
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_CMD_CHK_EN
  assign bus.cmd_err  = cmd_err_q;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Randomised bench for spi_slave against a frame-level reference model.
// Build with SPI_SLAVE_CMD_CHK_EN to also exercise the command check.
module tb_spi_slave;
  localparam int MAXK = 40;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(8)) bus();
  spi_slave #(.DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Reference state: read-address flag and last forwarded frame
  logic       m_flag = 1'b0;
  logic [9:0] m_rxd  = 10'h000;

  logic       obs_rxv[MAXK], obs_miso[MAXK], obs_err[MAXK];
  logic [9:0] obs_rxd[MAXK];
  logic       exp_rxv[MAXK], exp_miso[MAXK], exp_err[MAXK];
  logic [9:0] exp_rxd[MAXK];
  int         last_k;

  // SS_n low for edges 0..len-1, high at edge len; tx_valid pulse at edge 12+dly for read data
  task automatic run_txn(input logic [9:0] f, input int len, input int dly, input logic [7:0] td);
    bit   complete, err, rd_data, ok;
    int   n;
    logic tv;
    complete = (len >= 11);
    rd_data  = f[9] && m_flag;
    err      = 1'b0;
`ifdef SPI_SLAVE_CMD_CHK_EN
    if (f[9] && !m_flag && f[8])  err = 1'b1;
    if (f[9] &&  m_flag && !f[8]) err = 1'b1;
`endif
    ok = complete && !err;
    n  = 12 + dly;
    for (int k = 0; k <= len; k++) begin
      bus.SS_n    = (k < len) ? 1'b0 : 1'b1;
      bus.MOSI    = (k >= 1 && k <= 10) ? f[4'(10 - k)] : 1'($urandom);
      bus.tx_data = td;
      if (rd_data && ok) tv = (k == n) || (((k >= 1 && k <= 9) || k > n + 8) && 1'($urandom));
      else               tv = 1'($urandom);
      bus.tx_valid = tv;
      @(posedge clk);
      @(negedge clk);
      exp_rxv[k] = ok && (k == 10);
      exp_err[k] = complete && err && (k == 10);
      if (ok && k == 10) m_rxd = f;
      exp_rxd[k]  = m_rxd;
      exp_miso[k] = (rd_data && ok && k >= n && k <= n + 7 && k < len) ? td[3'(7 - (k - n))] : 1'b0;
      obs_rxv[k]  = bus.rx_valid;
      obs_rxd[k]  = bus.rx_data;
      obs_miso[k] = bus.MISO;
`ifdef SPI_SLAVE_CMD_CHK_EN
      obs_err[k]  = bus.cmd_err;
`else
      obs_err[k]  = 1'b0;
`endif
    end
    if (ok && f[9]) m_flag = ~m_flag;
    last_k = len;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    vectors += 3;
    if (bus.MISO !== 1'b0)       begin miscompares++; $display("FAIL reset MISO got %b exp 0", bus.MISO); end
    if (bus.rx_valid !== 1'b0)   begin miscompares++; $display("FAIL reset rx_valid got %b exp 0", bus.rx_valid); end
    if (bus.rx_data !== 10'h000) begin miscompares++; $display("FAIL reset rx_data got %h exp 000", bus.rx_data); end
`ifdef SPI_SLAVE_CMD_CHK_EN
    vectors++;
    if (bus.cmd_err !== 1'b0)    begin miscompares++; $display("FAIL reset cmd_err got %b exp 0", bus.cmd_err); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [9:0] f;
    for (int t = 0; t < 6; t++) begin
      f = (t == 0) ? 10'h0A5 : (t == 1) ? 10'h13C : {2'b0, 8'($urandom)};
      run_txn(f, (t < 2) ? 11 : 11 + $urandom_range(0, 3), 0, 8'($urandom));
      for (int k = 0; k <= last_k; k++) begin
        vectors += 3;
        if (obs_rxv[k] !== exp_rxv[k])   begin miscompares++; $display("FAIL write rx_valid t=%0d k=%0d got %b exp %b", t, k, obs_rxv[k], exp_rxv[k]); end
        if (obs_rxd[k] !== exp_rxd[k])   begin miscompares++; $display("FAIL write rx_data t=%0d k=%0d got %h exp %h", t, k, obs_rxd[k], exp_rxd[k]); end
        if (obs_miso[k] !== exp_miso[k]) begin miscompares++; $display("FAIL write MISO t=%0d k=%0d got %b exp %b", t, k, obs_miso[k], exp_miso[k]); end
      end
    end
  endtask

  task automatic test_read();
    logic [9:0] f;
    int dly;
    for (int t = 0; t < 8; t++) begin
      dly = (t < 2) ? 0 : $urandom_range(0, 3);
      if (t == 0)          run_txn(10'h207, 13, 0, 8'($urandom));
      else if (t == 1)     run_txn({2'b11, 8'($urandom)}, 21, 0, 8'hC3);
      else if (t % 2 == 0) run_txn({2'b10, 8'($urandom)}, 11 + $urandom_range(0, 3), 0, 8'($urandom));
      else begin
        f = {2'b11, 8'($urandom)};
        run_txn(f, 21 + dly + $urandom_range(0, 2), dly, 8'($urandom));
      end
      for (int k = 0; k <= last_k; k++) begin
        vectors += 3;
        if (obs_rxv[k] !== exp_rxv[k])   begin miscompares++; $display("FAIL read rx_valid t=%0d k=%0d got %b exp %b", t, k, obs_rxv[k], exp_rxv[k]); end
        if (obs_rxd[k] !== exp_rxd[k])   begin miscompares++; $display("FAIL read rx_data t=%0d k=%0d got %h exp %h", t, k, obs_rxd[k], exp_rxd[k]); end
        if (obs_miso[k] !== exp_miso[k]) begin miscompares++; $display("FAIL read MISO t=%0d k=%0d got %b exp %b", t, k, obs_miso[k], exp_miso[k]); end
      end
    end
  endtask

`ifdef SPI_SLAVE_CMD_CHK_EN
  task automatic test_cmd_chk();
    for (int t = 0; t < 5; t++) begin
      case (t)
        0:       run_txn(10'h301, 13, 0, 8'($urandom));
        1:       run_txn({2'b10, 8'($urandom)}, 12, 0, 8'($urandom));
        2:       run_txn({2'b10, 8'($urandom)}, 24, 0, 8'($urandom));
        3:       run_txn({2'b11, 8'($urandom)}, 22, 1, 8'($urandom));
        default: run_txn({2'b01, 8'($urandom)}, 12, 0, 8'($urandom));
      endcase
      for (int k = 0; k <= last_k; k++) begin
        vectors += 4;
        if (obs_rxv[k] !== exp_rxv[k])   begin miscompares++; $display("FAIL cmd_chk rx_valid t=%0d k=%0d got %b exp %b", t, k, obs_rxv[k], exp_rxv[k]); end
        if (obs_rxd[k] !== exp_rxd[k])   begin miscompares++; $display("FAIL cmd_chk rx_data t=%0d k=%0d got %h exp %h", t, k, obs_rxd[k], exp_rxd[k]); end
        if (obs_miso[k] !== exp_miso[k]) begin miscompares++; $display("FAIL cmd_chk MISO t=%0d k=%0d got %b exp %b", t, k, obs_miso[k], exp_miso[k]); end
        if (obs_err[k] !== exp_err[k])   begin miscompares++; $display("FAIL cmd_chk cmd_err t=%0d k=%0d got %b exp %b", t, k, obs_err[k], exp_err[k]); end
      end
    end
  endtask
`endif

  task automatic test_abort();
    for (int t = 0; t < 6; t++) begin
      case (t)
        0:       run_txn({2'b01, 8'($urandom)}, 7, 0, 8'($urandom));
        1:       run_txn(10'h1F0, 11, 0, 8'($urandom));
        2:       run_txn({2'b10, 8'($urandom)}, 5, 0, 8'($urandom));
        3:       run_txn({2'b10, 8'($urandom)}, 12, 0, 8'($urandom));
        4:       run_txn({2'b11, 8'($urandom)}, 16, 0, 8'($urandom));
        default: run_txn({2'b11, 8'($urandom)}, 22, 0, 8'($urandom));
      endcase
      for (int k = 0; k <= last_k; k++) begin
        vectors += 3;
        if (obs_rxv[k] !== exp_rxv[k])   begin miscompares++; $display("FAIL abort rx_valid t=%0d k=%0d got %b exp %b", t, k, obs_rxv[k], exp_rxv[k]); end
        if (obs_rxd[k] !== exp_rxd[k])   begin miscompares++; $display("FAIL abort rx_data t=%0d k=%0d got %h exp %h", t, k, obs_rxd[k], exp_rxd[k]); end
        if (obs_miso[k] !== exp_miso[k]) begin miscompares++; $display("FAIL abort MISO t=%0d k=%0d got %b exp %b", t, k, obs_miso[k], exp_miso[k]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] f;
    run_txn({2'b10, 8'h5A}, 13, 0, 8'h00);
    for (int k = 0; k <= last_k; k++) begin
      vectors += 2;
      if (obs_rxv[k] !== exp_rxv[k]) begin miscompares++; $display("FAIL pre_rst rx_valid k=%0d got %b exp %b", k, obs_rxv[k], exp_rxv[k]); end
      if (obs_rxd[k] !== exp_rxd[k]) begin miscompares++; $display("FAIL pre_rst rx_data k=%0d got %h exp %h", k, obs_rxd[k], exp_rxd[k]); end
    end
    // Read-data frame cut by reset after five MOSI bits
    f = {2'b11, 8'($urandom)};
    for (int k = 0; k <= 5; k++) begin
      bus.SS_n = 1'b0;
      bus.MOSI = (k >= 1) ? f[4'(10 - k)] : 1'b0;
      bus.tx_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    m_flag = 1'b0;
    m_rxd  = 10'h000;
    vectors += 3;
    if (bus.MISO !== 1'b0)       begin miscompares++; $display("FAIL mid_rst MISO got %b exp 0", bus.MISO); end
    if (bus.rx_valid !== 1'b0)   begin miscompares++; $display("FAIL mid_rst rx_valid got %b exp 0", bus.rx_valid); end
    if (bus.rx_data !== 10'h000) begin miscompares++; $display("FAIL mid_rst rx_data got %h exp 000", bus.rx_data); end
    @(negedge clk);
    bus.SS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      if (t == 0) run_txn({2'b10, 8'h33}, 24, 0, 8'($urandom));
      else        run_txn({2'b11, 8'($urandom)}, 22, 1, 8'($urandom));
      for (int k = 0; k <= last_k; k++) begin
        vectors += 3;
        if (obs_rxv[k] !== exp_rxv[k])   begin miscompares++; $display("FAIL post_rst rx_valid t=%0d k=%0d got %b exp %b", t, k, obs_rxv[k], exp_rxv[k]); end
        if (obs_rxd[k] !== exp_rxd[k])   begin miscompares++; $display("FAIL post_rst rx_data t=%0d k=%0d got %h exp %h", t, k, obs_rxd[k], exp_rxd[k]); end
        if (obs_miso[k] !== exp_miso[k]) begin miscompares++; $display("FAIL post_rst MISO t=%0d k=%0d got %b exp %b", t, k, obs_miso[k], exp_miso[k]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int dly, len;
    for (int t = 0; t < 40; t++) begin
      dly = $urandom_range(0, 3);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 24) : 21 + dly + $urandom_range(0, 2);
      run_txn(10'($urandom), len, dly, 8'($urandom));
      for (int k = 0; k <= last_k; k++) begin
        vectors += 3;
        if (obs_rxv[k] !== exp_rxv[k])   begin miscompares++; $display("FAIL b2b rx_valid t=%0d k=%0d got %b exp %b", t, k, obs_rxv[k], exp_rxv[k]); end
        if (obs_rxd[k] !== exp_rxd[k])   begin miscompares++; $display("FAIL b2b rx_data t=%0d k=%0d got %h exp %h", t, k, obs_rxd[k], exp_rxd[k]); end
        if (obs_miso[k] !== exp_miso[k]) begin miscompares++; $display("FAIL b2b MISO t=%0d k=%0d got %b exp %b", t, k, obs_miso[k], exp_miso[k]); end
`ifdef SPI_SLAVE_CMD_CHK_EN
        vectors++;
        if (obs_err[k] !== exp_err[k])   begin miscompares++; $display("FAIL b2b cmd_err t=%0d k=%0d got %b exp %b", t, k, obs_err[k], exp_err[k]); end
`endif
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
`ifdef SPI_SLAVE_CMD_CHK_EN
    test_cmd_chk();
`endif
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
